// File: rtl/tempo_keypad.sv
`default_nettype none
// ============================================================================
//  Module      : tempo_keypad
//  Description : Front-panel tempo entry. Synchronises and debounces four
//                push-buttons, converts each press into a tempo step with
//                hold-to-auto-repeat, and keeps a saturating 8-bit BPM value.
//  Revision    : 1.0  initial release
// ============================================================================
module tempo_keypad #(
    parameter int INIT_BPM        = 60,
    parameter int MIN_BPM         = 30,
    parameter int MAX_BPM         = 250,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD   = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       down,
    input  logic       up,
    output logic [7:0] speed,
    output logic       speed_upd
);

    // Button index order doubles as priority order: lowest index wins.
    localparam logic [1:0] c_BTN_LEFT  = 2'd0;
    localparam logic [1:0] c_BTN_RIGHT = 2'd1;
    localparam logic [1:0] c_BTN_DOWN  = 2'd2;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LAST  = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_LAST = c_TMR_W'(REPEAT_PERIOD - 1);

    localparam logic [7:0]        c_INIT_8    = 8'(INIT_BPM);
    localparam logic [7:0]        c_MIN_8     = 8'(MIN_BPM);
    localparam logic [7:0]        c_MAX_8     = 8'(MAX_BPM);
    localparam logic signed [9:0] c_MIN_S     = 10'(MIN_BPM);
    localparam logic signed [9:0] c_MAX_S     = 10'(MAX_BPM);
    localparam logic signed [9:0] c_STEP_FINE = 10'sd1;
    localparam logic signed [9:0] c_STEP_BIG  = 10'sd10;

    logic [3:0]         w_raw;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         w_deb;
    logic [3:0]         r_deb_d;
    logic [3:0]         w_rise;
    logic [1:0]         w_winner;
    logic [1:0]         w_step_idx;
    logic               w_apply;
    logic signed [9:0]  w_step;
    logic signed [9:0]  w_sum;
    logic [7:0]         w_clamped;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [1:0]         r_active;
    logic [1:0]         w_active_nxt;
    logic [7:0]         r_speed;
    logic               r_speed_upd;

    assign w_raw = {up, down, right, left};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_level;

        // Accept a new level only after it has differed for the full window
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[gi] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_level <= r_sync2[gi];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[gi] = r_level;
    end

    // Delayed debounced levels for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= w_deb;
        end
    end

    assign w_rise = w_deb & ~r_deb_d;

    // Pick the highest-priority rising edge
    always_comb begin
        w_winner = 2'd3;
        if (w_rise[0]) begin
            w_winner = 2'd0;
        end else if (w_rise[1]) begin
            w_winner = 2'd1;
        end else if (w_rise[2]) begin
            w_winner = 2'd2;
        end
    end

    // Press / hold / auto-repeat sequencing around a single shared timer
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_active_nxt = r_active;
        w_apply      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_rise) begin
                    w_apply      = 1'b1;
                    w_active_nxt = w_winner;
                    w_timer_nxt  = '0;
                    w_state_nxt  = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (!w_deb[r_active]) begin
                    w_timer_nxt = '0;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_timer == c_DELAY_LAST) begin
                    w_apply     = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_ST_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            c_ST_REPEAT: begin
                if (!w_deb[r_active]) begin
                    w_timer_nxt = '0;
                    w_state_nxt = c_ST_IDLE;
                end else if (r_timer == c_PERIOD_LAST) begin
                    w_apply     = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Step size and saturating sum; the sum is wide enough never to wrap
    always_comb begin
        w_step_idx = (r_state == c_ST_IDLE) ? w_winner : r_active;
        case (w_step_idx)
            c_BTN_LEFT:  w_step = -c_STEP_FINE;
            c_BTN_RIGHT: w_step = c_STEP_FINE;
            c_BTN_DOWN:  w_step = -c_STEP_BIG;
            default:     w_step = c_STEP_BIG;
        endcase
        w_sum = $signed({2'b00, r_speed}) + w_step;
        if (w_sum < c_MIN_S) begin
            w_clamped = c_MIN_8;
        end else if (w_sum > c_MAX_S) begin
            w_clamped = c_MAX_8;
        end else begin
            w_clamped = w_sum[7:0];
        end
    end

    // State, timer, tempo and update pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_active    <= c_BTN_LEFT;
            r_speed     <= c_INIT_8;
            r_speed_upd <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_active    <= w_active_nxt;
            r_speed_upd <= w_apply && (w_clamped != r_speed);
            if (w_apply) begin
                r_speed <= w_clamped;
            end
        end
    end

    assign speed     = r_speed;
    assign speed_upd = r_speed_upd;

endmodule
`default_nettype wire

// File: tb/tb_tempo_keypad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tempo_keypad
//  Description : Directed self-checking bench for tempo_keypad with short
//                debounce and repeat timings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tempo_keypad;

    localparam int c_LEFT  = 0;
    localparam int c_RIGHT = 1;
    localparam int c_DOWN  = 2;
    localparam int c_UP    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] r_btn = 4'b0000;
    logic [7:0] speed;
    logic       speed_upd;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    int base;

    tempo_keypad #(
        .INIT_BPM        (60),
        .MIN_BPM         (30),
        .MAX_BPM         (250),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .left      (r_btn[c_LEFT]),
        .right     (r_btn[c_RIGHT]),
        .down      (r_btn[c_DOWN]),
        .up        (r_btn[c_UP]),
        .speed     (speed),
        .speed_upd (speed_upd)
    );

    always #5 clk = ~clk;

    // Count update pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (speed_upd === 1'b1) upd_cnt++;
    end

    // Advance n rising edges and settle just after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        r_btn = 4'b0000;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    // Hold a button just long enough to produce exactly n steps, then release
    task automatic press_n(input int idx, input int n);
        int t;
        t = (n == 1) ? 8 : 23 + 5 * (n - 2);
        r_btn[idx] = 1'b1;
        cyc(t);
        r_btn[idx] = 1'b0;
        cyc(10);
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("reset_speed", 32'(speed), 32'd60);
        chk("reset_upd", 32'(speed_upd), 32'd0);

        // Button held through reset: seen as a fresh press after release
        r_btn[c_RIGHT] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_hold_speed", 32'(speed), 32'd60);
        end
        rst = 1'b0;
        cyc(6);
        chk("rst_latency_early", 32'(speed), 32'd60);
        cyc(1);
        chk("rst_latency_step", 32'(speed), 32'd61);
        chk("rst_latency_upd", 32'(speed_upd), 32'd1);
        cyc(1);
        chk("upd_one_cycle", 32'(speed_upd), 32'd0);
        r_btn = 4'b0000;
        cyc(10);

        // Bounce rejection
        do_reset();
        base = upd_cnt;
        for (int i = 0; i < 5; i++) begin
            r_btn[c_UP] = 1'b1;
            cyc(2);
            r_btn[c_UP] = 1'b0;
            cyc(2);
        end
        chk("bounce_quiet", 32'(speed), 32'd60);
        r_btn[c_UP] = 1'b1;
        cyc(10);
        chk("bounce_speed", 32'(speed), 32'd70);
        r_btn[c_UP] = 1'b0;
        cyc(10);
        chk("bounce_pulses", 32'(upd_cnt - base), 32'd1);

        // Auto-repeat: steps at edges 7, 27, 32, 37, ...
        do_reset();
        base = upd_cnt;
        r_btn[c_RIGHT] = 1'b1;
        cyc(6);
        chk("rep_before_first", 32'(speed), 32'd60);
        cyc(1);
        chk("rep_first", 32'(speed), 32'd61);
        cyc(19);
        chk("rep_before_delay", 32'(speed), 32'd61);
        cyc(1);
        chk("rep_after_delay", 32'(speed), 32'd62);
        cyc(4);
        chk("rep_before_period", 32'(speed), 32'd62);
        cyc(1);
        chk("rep_after_period", 32'(speed), 32'd63);
        cyc(28);
        chk("rep_at_60", 32'(speed), 32'd68);
        r_btn[c_RIGHT] = 1'b0;
        cyc(20);
        chk("rep_stopped", 32'(speed), 32'd69);
        chk("rep_pulses", 32'(upd_cnt - base), 32'd9);

        // Upper clamp
        do_reset();
        press_n(c_RIGHT, 5);
        press_n(c_UP, 18);
        chk("reach_245", 32'(speed), 32'd245);
        press_n(c_UP, 1);
        chk("clamp_hi", 32'(speed), 32'd250);
        base = upd_cnt;
        press_n(c_UP, 1);
        chk("clamp_hi_hold", 32'(speed), 32'd250);
        chk("clamp_hi_nopulse", 32'(upd_cnt - base), 32'd0);

        // Lower clamp
        do_reset();
        press_n(c_LEFT, 5);
        press_n(c_DOWN, 2);
        chk("reach_35", 32'(speed), 32'd35);
        base = upd_cnt;
        press_n(c_DOWN, 1);
        chk("clamp_lo", 32'(speed), 32'd30);
        chk("clamp_lo_pulse", 32'(upd_cnt - base), 32'd1);
        base = upd_cnt;
        press_n(c_LEFT, 1);
        chk("clamp_lo_hold", 32'(speed), 32'd30);
        chk("clamp_lo_nopulse", 32'(upd_cnt - base), 32'd0);

        // Priority and ignore-while-held
        do_reset();
        base = upd_cnt;
        r_btn[c_LEFT] = 1'b1;
        r_btn[c_UP]   = 1'b1;
        cyc(7);
        chk("prio_left_wins", 32'(speed), 32'd59);
        r_btn[c_UP]    = 1'b0;
        r_btn[c_RIGHT] = 1'b1;
        cyc(8);
        chk("ignore_right", 32'(speed), 32'd59);
        r_btn[c_LEFT] = 1'b0;
        cyc(15);
        chk("no_stale_right", 32'(speed), 32'd59);
        chk("prio_pulses", 32'(upd_cnt - base), 32'd1);
        r_btn = 4'b0000;
        cyc(10);

        // Reset during auto-repeat
        do_reset();
        r_btn[c_RIGHT] = 1'b1;
        cyc(35);
        chk("midrst_before", 32'(speed), 32'd63);
        rst = 1'b1;
        cyc(1);
        chk("midrst_speed", 32'(speed), 32'd60);
        chk("midrst_upd", 32'(speed_upd), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        chk("midrst_no_step", 32'(speed), 32'd60);
        cyc(1);
        chk("midrst_repress", 32'(speed), 32'd61);
        r_btn = 4'b0000;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
